tft_frame_streamer: RTL and testbench
=====================================

# tft_frame_streamer

Parametrised full-frame pixel source for the ILI9341 SPI display path. It replaces the fixed-colour, fixed-resolution pixel feeder with a valid/ready stream. The stream has configurable geometry, an N-entry mode palette, an optional border colour and frame-boundary-only mode switching. It sits between the pet/mode state machine (which drives `mode`) and the display controller (which consumes pixels).

## Interface
Parameters:
- `H_RES`, 240, pixels per line (≥2)
- `V_RES`, 320, lines per frame (≥2)
- `PIXEL_SIZE`, 16, RGB565 pixel width
- `N_MODES`, 5, number of valid modes (≤ 2^MODE_W)
- `MODE_W`, 3, mode select width
- `PALETTE`, {16'h0000,16'h780F,16'hF800,16'h07FF,16'hFFE0}, packed `N_MODES*PIXEL_SIZE`; entry i at bits [i*PIXEL_SIZE +: PIXEL_SIZE], so mode 0 = FFE0
- `BORDER`, 0, border thickness in pixels; 0 disables the border
- `BORDER_COLOR`, 16'h0000, border pixel value

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `mode` in MODE_W: requested mode, sampled only at frame start.
- `refresh` in 1: single-cycle pulse requesting a redraw in the same mode.
- `pix_data` out PIXEL_SIZE: current pixel.
- `pix_valid` out 1: pixel available.
- `pix_ready` in 1: consumer accepts the pixel.
- `pix_first` out 1: current pixel is (0,0).
- `pix_last` out 1: current pixel is (H_RES-1, V_RES-1).
- `frame_done` out 1: level; high while idle after a completed frame.
- `frame_count` out 8: completed frames, wraps 255→0.
- `mode_err` out 1: sticky; set when an out-of-range mode is latched.

## Operation
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE: entered only from reset. Moves to LOAD on the next cycle; the first frame is always drawn.
- LOAD (1 cycle):
  - Latch `mode` into `active_mode`. If `mode ≥ N_MODES`, latch 0 and set `mode_err`.
  - Select the palette colour.
  - Clear x, y and the pending-refresh flag.
  - Go to STREAM.
- STREAM:
  - `pix_valid`=1.
  - A transfer occurs on `pix_valid && pix_ready`.
  - On transfer: x++. At x==H_RES-1, x←0 and y++.
  - Transfer at the last pixel → DONE, and `frame_count`++.
- DONE:
  - `frame_done`=1, `pix_valid`=0.
  - Go to LOAD when `mode != active_mode`, the pending-refresh flag is set, or `refresh` is high this cycle.
  - Otherwise stay in DONE.
- Pixel value is a pure function of registered x, y and the active colour:
  - `BORDER_COLOR` if BORDER>0 and (x<BORDER or x≥H_RES-BORDER or y<BORDER or y≥V_RES-BORDER);
  - otherwise `PALETTE[active_mode]`.
- `mode` changes during STREAM are ignored until DONE; a frame is never mixed.
- `refresh` pulse in any state except IDLE sets the pending flag. A pulse in the LOAD cycle itself is dropped (LOAD clears the flag).
- `pix_first` = STREAM && x==0 && y==0. `pix_last` = STREAM && x==H_RES-1 && y==V_RES-1.
- Counter widths: x uses $clog2(H_RES) bits and y uses $clog2(V_RES) bits; neither exceeds its limit.

## Timing
- Reset (rst=0 at a clock edge):
  - state IDLE, x=y=0.
  - `pix_valid`=0, `pix_first`=0, `pix_last`=0, `frame_done`=0, `frame_count`=0, `mode_err`=0, `pix_data`=0.
- Reset asserted mid-frame aborts immediately. The partial frame is not counted.
- Sequence after reset release: cycle 1 IDLE, cycle 2 LOAD, cycle 3 STREAM with the first pixel valid.
- With `pix_ready` held high, a frame occupies exactly H_RES×V_RES STREAM cycles.
- DONE is asserted the cycle after the last transfer.
- Mode change or refresh while in DONE: LOAD on the next cycle, `pix_valid` two cycles after the trigger.
- Mode change during STREAM: a new frame starts 2 cycles after DONE entry.
- Stall (`pix_ready`=0): `pix_data`, `pix_first`, `pix_last`, x and y are held unchanged. `pix_valid` never drops mid-frame.
- Once asserted, `pix_valid` has no dependency on `pix_ready`.

## Test plan
All scenarios use H_RES=4, V_RES=3, BORDER=0 unless stated.
- **Reset and first frame:** release reset, `mode`=2, `pix_ready`=1 → `pix_valid` rises at cycle 3. Then 12 pixels of F800, `pix_first` on pixel 0, `pix_last` on pixel 11. `frame_done`=1 and `frame_count`=1 on the following cycle.
- **Mode change mid-frame:** `mode` 1→3 after 5 transfers → the remaining 7 pixels are 07FF. DONE lasts 1 cycle, then LOAD, then 12 pixels of 780F; `frame_count`=2.
- **Backpressure:** `pix_ready` toggles 1,0,0,1 repeatedly → each pixel is held during stalls. Exactly 12 transfers occur, x/y order is row-major, and `pix_valid` stays 1 throughout.
- **Refresh and error:**
  - Idle in DONE, pulse `refresh` → identical frame redrawn and `frame_count` increments.
  - Set `mode`=6 → frame of FFE0 and `mode_err`=1, which stays 1 after `mode` returns to 0.
- **Border:** BORDER=1, H_RES=V_RES=4, `mode`=0, `BORDER_COLOR`=0000 → only pixels (1,1), (2,1), (1,2), (2,2) are FFE0; the other 12 are 0000.
- **Reset mid-frame:** assert `rst`=0 after 6 transfers → next cycle has all outputs at reset values and `frame_count`=0. After release, the frame restarts at (0,0).

Source files
------------

// File: rtl/tft_frame_streamer.sv
// ---------------------------------------------------------------------------
// tft_frame_streamer
//
// Full-frame pixel source for the ILI9341 display path. Emits one frame of
// H_RES x V_RES pixels in row-major order on a valid/ready stream. Each frame
// uses one palette colour chosen by `mode`, optionally framed by a border of
// BORDER pixels in BORDER_COLOR. `mode` is only sampled at frame start, so a
// frame is never drawn in mixed colours.
//
// State table
//   state  | meaning
//   IDLE   | just out of reset; always proceeds to draw the first frame
//   LOAD   | one cycle: latch mode/colour, clear x/y and pending refresh
//   STREAM | presenting pixels; advance x/y on every accepted pixel
//   DONE   | frame complete; wait for a mode change or a refresh request
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-low reset
//   mode        in   requested mode, sampled in LOAD
//   refresh     in   single-cycle redraw request
//   pix_data    out  current pixel (RGB565 by default)
//   pix_valid   out  pixel available (STREAM)
//   pix_ready   in   consumer accepts current pixel
//   pix_first   out  current pixel is (0,0)
//   pix_last    out  current pixel is (H_RES-1, V_RES-1)
//   frame_done  out  level, high while waiting in DONE
//   frame_count out  completed frames, wraps at 256
//   mode_err    out  sticky, an out-of-range mode was latched
// ---------------------------------------------------------------------------
module tft_frame_streamer #(
  parameter int H_RES      = 240,
  parameter int V_RES      = 320,
  parameter int PIXEL_SIZE = 16,
  parameter int N_MODES    = 5,
  parameter int MODE_W     = 3,
  parameter logic [N_MODES*PIXEL_SIZE-1:0] PALETTE =
    {16'h0000, 16'h780F, 16'hF800, 16'h07FF, 16'hFFE0},
  parameter int BORDER     = 0,
  parameter logic [PIXEL_SIZE-1:0] BORDER_COLOR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  refresh,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_first,
  output logic                  pix_last,
  output logic                  frame_done,
  output logic [7:0]            frame_count,
  output logic                  mode_err
);

  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);

  localparam int X_MAX_I = H_RES - 1;
  localparam int Y_MAX_I = V_RES - 1;
  localparam logic [X_W-1:0] X_MAX = X_MAX_I[X_W-1:0];
  localparam logic [Y_W-1:0] Y_MAX = Y_MAX_I[Y_W-1:0];

  // Border limits carry one extra bit so H_RES - BORDER never aliases.
  localparam int BORDER_I = BORDER;
  localparam int XB_HI_I  = H_RES - BORDER;
  localparam int YB_HI_I  = V_RES - BORDER;
  localparam logic [X_W:0] XB_LO = BORDER_I[X_W:0];
  localparam logic [X_W:0] XB_HI = XB_HI_I[X_W:0];
  localparam logic [Y_W:0] YB_LO = BORDER_I[Y_W:0];
  localparam logic [Y_W:0] YB_HI = YB_HI_I[Y_W:0];

  // N_MODES may equal 2**MODE_W, so the range check needs one extra bit.
  localparam int N_MODES_I = N_MODES;
  localparam logic [MODE_W:0] N_MODES_L = N_MODES_I[MODE_W:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic [MODE_W-1:0]     r_active_mode;
  logic [PIXEL_SIZE-1:0] r_colour;
  logic                  r_refresh_pend;
  logic [7:0]            r_frame_count;
  logic                  r_mode_err;

  logic                  w_stream;
  logic                  w_xfer;
  logic                  w_x_end;
  logic                  w_y_end;
  logic                  w_last_xfer;
  logic                  w_mode_ok;
  logic [MODE_W-1:0]     w_load_mode;
  logic [PIXEL_SIZE-1:0] w_load_colour;
  logic                  w_in_border;
  logic                  w_redraw;

  assign w_stream    = (r_state == ST_STREAM);
  assign w_xfer      = w_stream && pix_ready;
  assign w_x_end     = (r_x == X_MAX);
  assign w_y_end     = (r_y == Y_MAX);
  assign w_last_xfer = w_xfer && w_x_end && w_y_end;

  assign w_mode_ok   = ({1'b0, mode} < N_MODES_L);
  assign w_load_mode = w_mode_ok ? mode : '0;

  // Constant-index loop keeps the palette lookup free of variable part-selects.
  always_comb begin
    w_load_colour = PALETTE[0 +: PIXEL_SIZE];
    for (int i = 0; i < N_MODES; i++) begin
      if (w_load_mode == MODE_W'(i)) begin
        w_load_colour = PALETTE[i*PIXEL_SIZE +: PIXEL_SIZE];
      end
    end
  end

  // Any of these in DONE starts a new frame; a refresh arriving in the same
  // cycle as DONE is honoured directly rather than via the pending flag.
  assign w_redraw = (mode != r_active_mode) || r_refresh_pend || refresh;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = ST_LOAD;
      ST_LOAD:   w_next_state = ST_STREAM;
      ST_STREAM: if (w_last_xfer) w_next_state = ST_DONE;
      ST_DONE:   if (w_redraw) w_next_state = ST_LOAD;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x            <= '0;
      r_y            <= '0;
      r_active_mode  <= '0;
      r_colour       <= '0;
      r_refresh_pend <= 1'b0;
      r_frame_count  <= 8'd0;
      r_mode_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_active_mode  <= w_load_mode;
          r_colour       <= w_load_colour;
          r_x            <= '0;
          r_y            <= '0;
          // Clearing here also drops a refresh pulse seen during LOAD itself.
          r_refresh_pend <= 1'b0;
          if (!w_mode_ok) begin
            r_mode_err <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (refresh) begin
            r_refresh_pend <= 1'b1;
          end
          if (w_xfer) begin
            if (w_x_end) begin
              r_x <= '0;
              // y wraps after the last line so it never exceeds V_RES-1.
              r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
          if (w_last_xfer) begin
            r_frame_count <= r_frame_count + 8'd1;
          end
        end
        ST_DONE: begin
          if (refresh) begin
            r_refresh_pend <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_in_border = 1'b0;
    if (BORDER > 0) begin
      w_in_border = ({1'b0, r_x} <  XB_LO) ||
                    ({1'b0, r_x} >= XB_HI) ||
                    ({1'b0, r_y} <  YB_LO) ||
                    ({1'b0, r_y} >= YB_HI);
    end
  end

  // Pixel is a function of registered x/y/colour only, so it holds during
  // stalls without extra storage. Outside STREAM it reads as zero.
  assign pix_data    = w_stream ? (w_in_border ? BORDER_COLOR : r_colour) : '0;
  assign pix_valid   = w_stream;
  assign pix_first   = w_stream && (r_x == '0) && (r_y == '0);
  assign pix_last    = w_stream && w_x_end && w_y_end;
  assign frame_done  = (r_state == ST_DONE);
  assign frame_count = r_frame_count;
  assign mode_err    = r_mode_err;

endmodule

// File: tb/tb_tft_frame_streamer.sv
module tb_tft_frame_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        refresh = 1'b0;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid, pix_first, pix_last, frame_done, mode_err;
  logic [7:0]  frame_count;

  logic [2:0]  mode_b = 3'd0;
  logic        refresh_b = 1'b0;
  logic        ready_b = 1'b0;
  logic [15:0] data_b;
  logic        valid_b, first_b, last_b, done_b, err_b;
  logic [7:0]  count_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  logic [15:0] pal [5] = '{16'hFFE0, 16'h07FF, 16'hF800, 16'h780F, 16'h0000};

  tft_frame_streamer #(.H_RES(4), .V_RES(3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .refresh(refresh),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_first(pix_first), .pix_last(pix_last), .frame_done(frame_done),
    .frame_count(frame_count), .mode_err(mode_err)
  );

  tft_frame_streamer #(.H_RES(4), .V_RES(4), .BORDER(1), .BORDER_COLOR(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .mode(mode_b), .refresh(refresh_b),
    .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b),
    .pix_first(first_b), .pix_last(last_b), .frame_done(done_b),
    .frame_count(count_b), .mode_err(err_b)
  );

  // Reference: colour for a requested mode (out-of-range falls back to mode 0).
  function automatic logic [15:0] ref_colour(input int m);
    return (m < 5) ? pal[m] : pal[0];
  endfunction

  // Reference: k-th pixel of a 4x4 frame with a 1-pixel black border, mode 0.
  function automatic logic [15:0] ref_border_pixel(input int k);
    int x, y;
    x = k % 4;
    y = k / 4;
    return (x < 1 || x >= 3 || y < 1 || y >= 3) ? 16'h0000 : pal[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumes one 12-pixel frame from the main DUT, starting at a sample point
  // where the frame's first pixel should be presented. rdy_mode: 0 always
  // ready, 1 pattern 1,0,0,1, 2 random. Optionally changes mode or pulses
  // refresh once the given number of transfers have happened.
  task automatic drain_frame(input logic [15:0] colour, input int rdy_mode,
                             input int chg_at, input logic [2:0] chg_mode,
                             input int rf_at, output int xfers);
    int k;
    int c;
    bit rf_done;
    k = 0;
    c = 0;
    rf_done = 0;
    while (k < 12 && c < 400) begin
      if (k == chg_at) mode = chg_mode;
      refresh = 1'b0;
      if (k == rf_at && !rf_done) begin
        refresh = 1'b1;
        rf_done = 1;
      end
      n_checks++;
      if (pix_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_valid k=%0d got=%b want=1", k, pix_valid);
      end
      n_checks++;
      if (pix_data !== colour) begin
        n_fail++;
        $display("FAIL stream_data k=%0d got=%h want=%h", k, pix_data, colour);
      end
      n_checks++;
      if (pix_first !== (k == 0)) begin
        n_fail++;
        $display("FAIL stream_first k=%0d got=%b want=%b", k, pix_first, (k == 0));
      end
      n_checks++;
      if (pix_last !== (k == 11)) begin
        n_fail++;
        $display("FAIL stream_last k=%0d got=%b want=%b", k, pix_last, (k == 11));
      end
      n_checks++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_done k=%0d got=%b want=0", k, frame_done);
      end
      case (rdy_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (pix_valid && pix_ready) k++;
      c++;
      tick();
    end
    refresh = 1'b0;
    n_checks++;
    if (c >= 400) begin
      n_fail++;
      $display("FAIL frame_timeout transfers=%0d want=12", k);
    end
    xfers = k;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({pix_valid, pix_first, pix_last, frame_done, mode_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=00000",
               {pix_valid, pix_first, pix_last, frame_done, mode_err});
    end
    n_checks++;
    if (frame_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d want=0", frame_count);
    end
    n_checks++;
    if (pix_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data got=%h want=0000", pix_data);
    end
    n_checks++;
    if ({valid_b, done_b, count_b} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_b got=%b want=0", {valid_b, done_b, count_b});
    end
  endtask

  task automatic test_first_frame();
    int xf;
    mode = 3'd2;
    pix_ready = 1'b1;
    rst = 1'b1;
    tick();
    n_checks++;
    if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL first_load valid=%b done=%b want=0,0", pix_valid, frame_done);
    end
    tick();
    n_checks++;
    if (pix_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_valid_cycle3 got=%b want=1", pix_valid);
    end
    drain_frame(ref_colour(2), 0, -1, 3'd0, -1, xf);
    exp_count = 1;
    n_checks++;
    if (frame_done !== 1'b1 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_done done=%b valid=%b want=1,0", frame_done, pix_valid);
    end
    n_checks++;
    if (frame_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL first_count got=%0d want=%0d", frame_count, exp_count);
    end
  endtask

  task automatic test_mode_change();
    int xf;
    mode = 3'd1;
    tick();
    n_checks++;
    if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_load valid=%b done=%b want=0,0", pix_valid, frame_done);
    end
    tick();
    drain_frame(ref_colour(1), 2, 5, 3'd3, -1, xf);
    exp_count++;
    n_checks++;
    if (frame_done !== 1'b1 || frame_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL mc_done1 done=%b count=%0d want=1,%0d", frame_done, frame_count, exp_count);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_reload done=%b valid=%b want=0,0", frame_done, pix_valid);
    end
    tick();
    drain_frame(ref_colour(3), 0, -1, 3'd0, -1, xf);
    exp_count++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (frame_done !== 1'b1 || frame_count !== 8'(exp_count)) begin
        n_fail++;
        $display("FAIL mc_hold i=%0d done=%b count=%0d want=1,%0d", i, frame_done, frame_count, exp_count);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int xf;
    mode = 3'd0;
    tick();
    tick();
    drain_frame(ref_colour(0), 1, -1, 3'd0, -1, xf);
    exp_count++;
    n_checks++;
    if (xf !== 12) begin
      n_fail++;
      $display("FAIL bp_transfers got=%0d want=12", xf);
    end
    n_checks++;
    if (frame_done !== 1'b1 || frame_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL bp_done done=%b count=%0d want=1,%0d", frame_done, frame_count, exp_count);
    end
  endtask

  task automatic test_refresh();
    int xf;
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    n_checks++;
    if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rf_load valid=%b done=%b want=0,0", pix_valid, frame_done);
    end
    tick();
    drain_frame(ref_colour(0), 2, -1, 3'd0, 4, xf);
    exp_count++;
    n_checks++;
    if (frame_done !== 1'b1 || frame_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL rf_done1 done=%b count=%0d want=1,%0d", frame_done, frame_count, exp_count);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rf_pending_reload done=%b want=0", frame_done);
    end
    tick();
    drain_frame(ref_colour(0), 2, -1, 3'd0, -1, xf);
    exp_count++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (frame_done !== 1'b1 || frame_count !== 8'(exp_count)) begin
        n_fail++;
        $display("FAIL rf_idle i=%0d done=%b count=%0d want=1,%0d", i, frame_done, frame_count, exp_count);
      end
      tick();
    end
    mode = 3'd3;
    tick();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    drain_frame(ref_colour(3), 0, -1, 3'd0, -1, xf);
    exp_count++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (frame_done !== 1'b1 || frame_count !== 8'(exp_count)) begin
        n_fail++;
        $display("FAIL rf_load_drop i=%0d done=%b count=%0d want=1,%0d", i, frame_done, frame_count, exp_count);
      end
      tick();
    end
  endtask

  task automatic test_mode_err();
    int xf;
    n_checks++;
    if (mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_before got=%b want=0", mode_err);
    end
    mode = 3'd6;
    tick();
    tick();
    n_checks++;
    if (mode_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got=%b want=1", mode_err);
    end
    drain_frame(ref_colour(6), 2, -1, 3'd0, -1, xf);
    exp_count++;
    mode = 3'd0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (frame_done !== 1'b1 || mode_err !== 1'b1 || frame_count !== 8'(exp_count)) begin
        n_fail++;
        $display("FAIL err_sticky i=%0d done=%b err=%b count=%0d want=1,1,%0d",
                 i, frame_done, mode_err, frame_count, exp_count);
      end
      tick();
    end
  endtask

  task automatic test_border();
    int k;
    int c;
    k = 0;
    c = 0;
    n_checks++;
    if (valid_b !== 1'b1 || first_b !== 1'b1) begin
      n_fail++;
      $display("FAIL border_stalled valid=%b first=%b want=1,1", valid_b, first_b);
    end
    while (k < 16 && c < 400) begin
      n_checks++;
      if (valid_b !== 1'b1 || data_b !== ref_border_pixel(k)) begin
        n_fail++;
        $display("FAIL border_pixel k=%0d valid=%b got=%h want=%h", k, valid_b, data_b, ref_border_pixel(k));
      end
      n_checks++;
      if (first_b !== (k == 0) || last_b !== (k == 15)) begin
        n_fail++;
        $display("FAIL border_flags k=%0d first=%b last=%b", k, first_b, last_b);
      end
      ready_b = 1'($urandom_range(0, 1));
      if (valid_b && ready_b) k++;
      c++;
      tick();
    end
    ready_b = 1'b0;
    n_checks++;
    if (c >= 400) begin
      n_fail++;
      $display("FAIL border_timeout transfers=%0d want=16", k);
    end
    n_checks++;
    if (done_b !== 1'b1 || count_b !== 8'd1 || err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL border_done done=%b count=%0d err=%b want=1,1,0", done_b, count_b, err_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    int xf;
    mode = 3'd2;
    tick();
    tick();
    pix_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== ref_colour(2)) begin
        n_fail++;
        $display("FAIL rm_pre i=%0d valid=%b data=%h want=1,%h", i, pix_valid, pix_data, ref_colour(2));
      end
      tick();
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({pix_valid, pix_first, pix_last, frame_done, mode_err} !== 5'b0 ||
        pix_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL rm_flags got=%b data=%h want=00000,0000",
               {pix_valid, pix_first, pix_last, frame_done, mode_err}, pix_data);
    end
    n_checks++;
    if (frame_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rm_count got=%0d want=0", frame_count);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_load valid=%b want=0", pix_valid);
    end
    tick();
    drain_frame(ref_colour(2), 2, -1, 3'd0, -1, xf);
    exp_count = 1;
    n_checks++;
    if (frame_done !== 1'b1 || frame_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL rm_restart done=%b count=%0d want=1,%0d", frame_done, frame_count, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_mode_change();
    test_backpressure();
    test_refresh();
    test_mode_err();
    test_border();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
